// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller: line field layout,
// table write-type encodings, FSM state encoding and a word-select helper.
package cache_ctrl_pkg;

  localparam int CacheTagWidth    = 20;
  localparam int CacheIndexWidth  = 8;
  localparam int CacheOffsetWidth = 4;

  // One way of a table line: {tag, valid, dirty, data[127:0]}
  localparam int LineW     = 150;
  localparam int LineTagHi = 149;
  localparam int LineTagLo = 130;
  localparam int LineValid = 129;
  localparam int LineDirty = 128;

  // Table write types driven on tbl_w_type_o
  localparam logic [1:0] WTypeRead = 2'b00;
  localparam logic [1:0] WTypePart = 2'b01;
  localparam logic [1:0] WTypeLine = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MISS   = 3'd2,
    ST_REFILL = 3'd3,
    ST_FILL   = 3'd4,
    ST_WRITE  = 3'd5
  } cache_state_e;

  // Pick 32-bit word 'sel' out of a 128-bit line payload
  function automatic logic [31:0] line_word(input logic [127:0] data, input logic [1:0] sel);
    return data[sel*32 +: 32];
  endfunction

endpackage

// File: rtl/cache_ctrl_hit_cmp.sv
// Combinational tag/valid compare over both ways of a table read.
// Way0 has priority when both ways report a hit.
module cache_hit_cmp
  import cache_ctrl_pkg::*;
(
  input  logic [2*LineW-1:0]       rd_data,
  input  logic [CacheTagWidth-1:0] tag,
  input  logic [1:0]               word_sel,
  output logic                     hit,
  output logic                     hit_way,
  output logic [31:0]              word
);

  logic [LineW-1:0] line0;
  logic [LineW-1:0] line1;
  logic             hit0;
  logic             hit1;
  logic             unused_dirty;

  assign line0        = rd_data[LineW-1:0];
  assign line1        = rd_data[2*LineW-1:LineW];
  assign hit0         = line0[LineValid] && (line0[LineTagHi:LineTagLo] == tag);
  assign hit1         = line1[LineValid] && (line1[LineTagHi:LineTagLo] == tag);
  assign unused_dirty = line0[LineDirty] ^ line1[LineDirty];

  // Resolve the hitting way and select the addressed word from it
  always_comb begin
    hit     = hit0 | hit1;
    hit_way = !hit0 && hit1;
    word    = hit_way ? line_word(line1[127:0], word_sel) : line_word(line0[127:0], word_sel);
  end

endmodule

// File: rtl/cache_ctrl.sv
// Cache control FSM for a 2-way, write-through, no-write-allocate cache.
// Handshakes: rd_req_o / wr_req_o are held high with stable address and data
// until the matching ready input is seen high in the same cycle; a ready
// input is ignored while its request is low.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_i,
  input  logic                cpu_wr_i,
  input  logic [31:0]         cpu_addr_i,
  input  logic [3:0]          cpu_wstrb_i,
  input  logic [31:0]         cpu_wdata_i,
  output logic                cpu_addr_ok_o,
  output logic                cpu_data_ok_o,
  output logic [31:0]         cpu_rdata_o,
  output logic                tbl_req_o,
  output logic [INDEX_W-1:0]  tbl_r_index_o,
  input  logic [299:0]        tbl_r_data_i,
  output logic                tbl_way_o,
  output logic [INDEX_W-1:0]  tbl_w_index_o,
  output logic [1:0]          tbl_w_type_o,
  output logic [OFFSET_W-1:0] tbl_offset_o,
  output logic [3:0]          tbl_wstrb_o,
  output logic [149:0]        tbl_w_data_o,
  output logic                rd_req_o,
  output logic [31:0]         rd_addr_o,
  input  logic                rd_rdy_i,
  input  logic                ret_valid_i,
  input  logic                ret_last_i,
  input  logic [31:0]         ret_data_i,
  output logic                wr_req_o,
  output logic [31:0]         wr_addr_o,
  output logic [3:0]          wr_wstrb_o,
  output logic [31:0]         wr_data_o,
  input  logic                wr_rdy_i,
  output cache_state_e        dbg_state_o
);

  cache_state_e state_q, state_d;

  logic [31:0]      req_addr_q;
  logic             req_wr_q;
  logic [3:0]       req_wstrb_q;
  logic [31:0]      req_wdata_q;
  logic             hit_q;
  logic             hit_way_q;
  logic             wr_first_q;
  logic             victim_q;
  logic [1:0]       cnt_q;
  logic [31:0]      buf_q [4];

  logic             hit;
  logic             hit_way;
  logic [31:0]      hit_word;
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_W-1:0] req_index;

  assign req_tag     = req_addr_q[31 -: TAG_W];
  assign req_index   = req_addr_q[OFFSET_W +: INDEX_W];
  assign dbg_state_o = state_q;

  cache_hit_cmp u_hit_cmp (
    .rd_data  (tbl_r_data_i),
    .tag      (req_tag),
    .word_sel (req_addr_q[3:2]),
    .hit      (hit),
    .hit_way  (hit_way),
    .word     (hit_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the CPU request when it is accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      req_wr_q    <= 1'b0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
    end else if (state_q == ST_IDLE && cpu_req_i) begin
      req_addr_q  <= cpu_addr_i;
      req_wr_q    <= cpu_wr_i;
      req_wstrb_q <= cpu_wstrb_i;
      req_wdata_q <= cpu_wdata_i;
    end
  end

  // Remember the lookup result for the store path; table write only in first WRITE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      hit_way_q  <= 1'b0;
      wr_first_q <= 1'b0;
    end else if (state_q == ST_LOOKUP) begin
      hit_q      <= hit;
      hit_way_q  <= hit_way;
      wr_first_q <= req_wr_q;
    end else if (state_q == ST_WRITE) begin
      wr_first_q <= 1'b0;
    end
  end

  // Global round-robin victim, flipped on every line fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 victim_q <= 1'b0;
    else if (state_q == ST_FILL) victim_q <= ~victim_q;
  end

  // Refill buffer: beats land at buf[cnt]; words not reached keep stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else if (state_q == ST_MISS) begin
      cnt_q <= '0;
    end else if (state_q == ST_REFILL && ret_valid_i) begin
      buf_q[cnt_q] <= ret_data_i;
      cnt_q        <= cnt_q + 2'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cpu_req_i) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (req_wr_q)  state_d = ST_WRITE;
        else if (hit)  state_d = ST_IDLE;
        else           state_d = ST_MISS;
      end
      ST_MISS:   if (rd_rdy_i) state_d = ST_REFILL;
      ST_REFILL: if (ret_valid_i && ret_last_i) state_d = ST_FILL;
      ST_FILL:   state_d = ST_IDLE;
      ST_WRITE:  if (wr_rdy_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode; every output idles at zero except cpu_addr_ok_o in IDLE
  always_comb begin
    cpu_addr_ok_o = 1'b0;
    cpu_data_ok_o = 1'b0;
    cpu_rdata_o   = '0;
    tbl_req_o     = 1'b0;
    tbl_r_index_o = '0;
    tbl_way_o     = 1'b0;
    tbl_w_index_o = '0;
    tbl_w_type_o  = WTypeRead;
    tbl_offset_o  = '0;
    tbl_wstrb_o   = '0;
    tbl_w_data_o  = '0;
    rd_req_o      = 1'b0;
    rd_addr_o     = '0;
    wr_req_o      = 1'b0;
    wr_addr_o     = '0;
    wr_wstrb_o    = '0;
    wr_data_o     = '0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_addr_ok_o = 1'b1;
        if (cpu_req_i) begin
          tbl_req_o     = 1'b1;
          tbl_r_index_o = cpu_addr_i[OFFSET_W +: INDEX_W];
        end
      end
      ST_LOOKUP: begin
        if (!req_wr_q && hit) begin
          cpu_data_ok_o = 1'b1;
          cpu_rdata_o   = hit_word;
        end
      end
      ST_MISS: begin
        rd_req_o  = 1'b1;
        rd_addr_o = {req_addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      ST_FILL: begin
        tbl_req_o     = 1'b1;
        tbl_w_type_o  = WTypeLine;
        tbl_way_o     = victim_q;
        tbl_w_index_o = req_index;
        tbl_w_data_o  = {req_tag, 1'b1, 1'b0, buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
        cpu_data_ok_o = 1'b1;
        cpu_rdata_o   = buf_q[req_addr_q[3:2]];
      end
      ST_WRITE: begin
        if (hit_q && wr_first_q) begin
          tbl_req_o     = 1'b1;
          tbl_w_type_o  = WTypePart;
          tbl_way_o     = hit_way_q;
          tbl_w_index_o = req_index;
          tbl_offset_o  = req_addr_q[OFFSET_W-1:0];
          tbl_wstrb_o   = req_wstrb_q;
          tbl_w_data_o  = {{(LineW-32){1'b0}}, req_wdata_q};
        end
        wr_req_o      = 1'b1;
        wr_addr_o     = {req_addr_q[31:2], 2'b00};
        wr_wstrb_o    = req_wstrb_q;
        wr_data_o     = req_wdata_q;
        cpu_data_ok_o = wr_rdy_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural 2-way table, memory bus responders,
// a cache-level reference model feeding expected queues, and a monitor.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cpu_req_i = 0, cpu_wr_i = 0;
  logic [31:0]  cpu_addr_i = 0, cpu_wdata_i = 0;
  logic [3:0]   cpu_wstrb_i = 0;
  logic         cpu_addr_ok_o, cpu_data_ok_o;
  logic [31:0]  cpu_rdata_o;
  logic         tbl_req_o, tbl_way_o;
  logic [7:0]   tbl_r_index_o, tbl_w_index_o;
  logic [299:0] tbl_r_data_i = '0;
  logic [1:0]   tbl_w_type_o;
  logic [3:0]   tbl_offset_o, tbl_wstrb_o;
  logic [149:0] tbl_w_data_o;
  logic         rd_req_o, rd_rdy_i = 0;
  logic [31:0]  rd_addr_o;
  logic         ret_valid_i = 0, ret_last_i = 0;
  logic [31:0]  ret_data_i = 0;
  logic         wr_req_o, wr_rdy_i = 0;
  logic [31:0]  wr_addr_o, wr_data_o;
  logic [3:0]   wr_wstrb_o;
  cache_state_e dbg_state_o;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wstrb_i(cpu_wstrb_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_addr_ok_o(cpu_addr_ok_o), .cpu_data_ok_o(cpu_data_ok_o), .cpu_rdata_o(cpu_rdata_o),
    .tbl_req_o(tbl_req_o), .tbl_r_index_o(tbl_r_index_o), .tbl_r_data_i(tbl_r_data_i),
    .tbl_way_o(tbl_way_o), .tbl_w_index_o(tbl_w_index_o), .tbl_w_type_o(tbl_w_type_o),
    .tbl_offset_o(tbl_offset_o), .tbl_wstrb_o(tbl_wstrb_o), .tbl_w_data_o(tbl_w_data_o),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_rdy_i(rd_rdy_i),
    .ret_valid_i(ret_valid_i), .ret_last_i(ret_last_i), .ret_data_i(ret_data_i),
    .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_wstrb_o(wr_wstrb_o),
    .wr_data_o(wr_data_o), .wr_rdy_i(wr_rdy_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_beat_cyc = 0;
  int rd_delay_cfg = -1;
  int wr_delay_cfg = -1;
  bit manual = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s (unexpected event) t=%0t", nm, $time);
  endtask

  // ---------------- table model (registered read) ----------------
  logic [149:0] tbl_mem [2][256];

  always @(posedge clk) begin
    logic [149:0] l;
    if (tbl_req_o) begin
      case (tbl_w_type_o)
        2'b00: tbl_r_data_i <= {tbl_mem[1][tbl_r_index_o], tbl_mem[0][tbl_r_index_o]};
        2'b10: tbl_mem[tbl_way_o][tbl_w_index_o] = tbl_w_data_o;
        2'b01: begin
          l = tbl_mem[tbl_way_o][tbl_w_index_o];
          for (int b = 0; b < 4; b++)
            if (tbl_wstrb_o[b]) l[tbl_offset_o[3:2]*32 + b*8 +: 8] = tbl_w_data_o[b*8 +: 8];
          tbl_mem[tbl_way_o][tbl_w_index_o] = l;
        end
        default: ;
      endcase
    end
  end

  // ---------------- memories and reference model ----------------
  logic [31:0] bus_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  logic [19:0]  ref_tag   [2][256];
  logic         ref_valid [2][256];
  logic [127:0] ref_line  [2][256];
  logic         ref_victim = 0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : hash(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hash(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = n[b*8 +: 8];
    return o;
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [33:0]  exp_q [$];    // {kind 0=load hit 1=load miss 2=store, rdata}
  logic [31:0]  rd_exp_q [$];
  logic [67:0]  wr_exp_q [$]; // {addr, strb, data}
  logic [168:0] tw_exp_q [$]; // {way, index, type, offset, strb, data}

  // Put a table line into both the table model and the reference model
  task automatic preload(input int way, input logic [7:0] idx, input logic [19:0] tag,
                         input logic [127:0] data);
    tbl_mem[way][idx]   = {tag, 1'b1, 1'b0, data};
    ref_tag[way][idx]   = tag;
    ref_valid[way][idx] = 1'b1;
    ref_line[way][idx]  = data;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd);
    logic [7:0]   idx;
    logic [19:0]  tag;
    logic [1:0]   w;
    logic [31:0]  la;
    logic [127:0] line;
    logic [1:0]   kind;
    bit           hit;
    int           way, start, cycles;
    idx = addr[11:4]; tag = addr[31:12]; w = addr[3:2]; la = {addr[31:4], 4'b0};
    hit = 0; way = 0;
    if (ref_valid[0][idx] && ref_tag[0][idx] == tag) begin hit = 1; way = 0; end
    else if (ref_valid[1][idx] && ref_tag[1][idx] == tag) begin hit = 1; way = 1; end
    if (!wr) begin
      if (hit) begin
        kind = 2'd0;
        exp_q.push_back({kind, ref_line[way][idx][w*32 +: 32]});
      end else begin
        kind = 2'd1;
        for (int k = 0; k < 4; k++) line[k*32 +: 32] = ref_rd(la + 32'(k*4));
        rd_exp_q.push_back(la);
        tw_exp_q.push_back({ref_victim, idx, 2'b10, 8'h00, tag, 1'b1, 1'b0, line});
        ref_tag[ref_victim][idx]   = tag;
        ref_valid[ref_victim][idx] = 1'b1;
        ref_line[ref_victim][idx]  = line;
        ref_victim = ~ref_victim;
        exp_q.push_back({kind, line[w*32 +: 32]});
      end
    end else begin
      kind = 2'd2;
      if (hit) begin
        tw_exp_q.push_back({way[0], idx, 2'b01, addr[3:0], strb, 118'b0, wd});
        ref_line[way][idx][w*32 +: 32] = merge(ref_line[way][idx][w*32 +: 32], wd, strb);
      end
      wr_exp_q.push_back({addr[31:2], 2'b00, strb, wd});
      ref_mem[{addr[31:2], 2'b00}] = merge(ref_rd({addr[31:2], 2'b00}), wd, strb);
      exp_q.push_back({kind, 32'h0});
    end
    check("addr_ok_idle", cpu_addr_ok_o, 1);
    cpu_req_i = 1; cpu_wr_i = wr; cpu_addr_i = addr; cpu_wstrb_i = strb; cpu_wdata_i = wd;
    start = done_cnt;
    @(posedge clk); #1;
    cpu_req_i = 0; cpu_wr_i = $urandom_range(0, 1); cpu_addr_i = $urandom;
    cpu_wdata_i = $urandom;
    cycles = 0;
    while (done_cnt == start && cycles < 300) begin @(posedge clk); #1; cycles++; end
    if (done_cnt == start) flag("request_timeout");
    else if (kind == 2'd0) check("hit_latency", cycles, 1);
  endtask

  // ---------------- monitor ----------------
  logic [33:0]  mon_e;
  logic [168:0] mon_t, mon_a;
  always @(negedge clk) begin
    if (rst_n && !manual) begin
      if (cpu_data_ok_o) begin
        if (exp_q.size() == 0) flag("data_ok_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          if (mon_e[33:32] != 2'd2) check("rdata", cpu_rdata_o, mon_e[31:0]);
          if (mon_e[33:32] == 2'd1) check("miss_latency", cyc, last_beat_cyc + 1);
        end
        done_cnt++;
      end
      if (tbl_req_o && tbl_w_type_o != 2'b00) begin
        if (tw_exp_q.size() == 0) flag("tbl_write_unexpected");
        else begin
          mon_t = tw_exp_q.pop_front();
          if (tbl_w_type_o == 2'b10)
            mon_a = {tbl_way_o, tbl_w_index_o, tbl_w_type_o, 8'h00, tbl_w_data_o};
          else
            mon_a = {tbl_way_o, tbl_w_index_o, tbl_w_type_o, tbl_offset_o, tbl_wstrb_o,
                     118'b0, tbl_w_data_o[31:0]};
          check("tbl_write", mon_a, mon_t);
        end
      end
    end
  end

  // ---------------- memory read responder ----------------
  initial begin
    logic [31:0] a;
    int d;
    forever begin
      @(posedge clk); #1;
      if (!manual && rst_n && rd_req_o) begin
        a = rd_addr_o;
        d = (rd_delay_cfg >= 0) ? rd_delay_cfg : $urandom_range(0, 3);
        repeat (d) begin
          ret_valid_i = $urandom_range(0, 1);   // stray beats outside REFILL
          ret_data_i  = $urandom;
          @(posedge clk); #1;
          check("rd_req_hold", rd_req_o, 1);
          check("rd_addr_hold", rd_addr_o, a);
        end
        ret_valid_i = 0;
        if (rd_exp_q.size() == 0) flag("rd_req_unexpected");
        else check("rd_addr", a, rd_exp_q.pop_front());
        rd_rdy_i = 1;
        @(posedge clk); #1;
        rd_rdy_i = 0;
        for (int k = 0; k < 4; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          ret_valid_i = 1;
          ret_data_i  = bus_rd(a + 32'(k*4));
          ret_last_i  = (k == 3);
          if (k == 3) last_beat_cyc = cyc;
          @(posedge clk); #1;
          ret_valid_i = 0;
          ret_last_i  = 0;
        end
      end
    end
  end

  // ---------------- memory write responder ----------------
  initial begin
    logic [31:0] a, dt;
    logic [3:0]  s;
    int d;
    forever begin
      @(posedge clk); #1;
      if (!manual && rst_n && wr_req_o) begin
        a = wr_addr_o; s = wr_wstrb_o; dt = wr_data_o;
        d = (wr_delay_cfg >= 0) ? wr_delay_cfg : $urandom_range(0, 3);
        repeat (d) begin
          @(posedge clk); #1;
          check("wr_hold", {wr_req_o, wr_addr_o, wr_wstrb_o, wr_data_o}, {1'b1, a, s, dt});
        end
        if (wr_exp_q.size() == 0) flag("wr_req_unexpected");
        else check("wr_req", {a, s, dt}, wr_exp_q.pop_front());
        bus_mem[a] = merge(bus_rd(a), dt, s);
        wr_rdy_i = 1;
        @(posedge clk); #1;
        wr_rdy_i = 0;
      end
    end
  end

  // ---------------- reset-value check ----------------
  task automatic check_reset_outputs(input string nm);
    check({nm, "_addr_ok"}, cpu_addr_ok_o, 1);
    check({nm, "_others"},
          {cpu_data_ok_o, cpu_rdata_o, tbl_req_o, tbl_r_index_o, tbl_way_o, tbl_w_index_o,
           tbl_w_type_o, tbl_offset_o, tbl_wstrb_o, tbl_w_data_o, rd_req_o, rd_addr_o,
           wr_req_o, wr_addr_o, wr_wstrb_o, wr_data_o, dbg_state_o}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    flag("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] a;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) begin
        tbl_mem[w][i] = '0; ref_valid[w][i] = 0; ref_tag[w][i] = '0; ref_line[w][i] = '0;
      end
    preload(0, 8'h23, 20'h00001, {32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h0000_0000});
    preload(0, 8'h40, 20'h00007, {96'h0, 32'h0A0A_0A0A});
    preload(1, 8'h40, 20'h00007, {96'h0, 32'h1B1B_1B1B});
    for (int k = 0; k < 4; k++) begin
      bus_mem[32'h2030 + 32'(k*4)] = 32'h11 * (k + 1);
      ref_mem[32'h2030 + 32'(k*4)] = 32'h11 * (k + 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // directed cases
    issue(0, 32'h0000_1234, 4'h0, 0);           // load hit way0 word1
    issue(0, 32'h0000_2038, 4'h0, 0);           // load miss, fills way0
    issue(0, 32'h0000_5030, 4'h0, 0);           // miss in same set, fills way1
    wr_delay_cfg = 3;
    issue(1, 32'h0000_5034, 4'b0011, 32'h0000_AABB);  // store hit way1
    wr_delay_cfg = -1;
    issue(0, 32'h0000_5034, 4'h0, 0);           // read back merged word
    issue(1, 32'h0000_9990, 4'hF, 32'h1234_5678);     // store miss
    issue(0, 32'h0000_9990, 4'h0, 0);           // load miss sees stored word
    issue(0, 32'h0000_7400, 4'h0, 0);           // both ways hit, way0 wins
    rd_delay_cfg = 5;
    issue(0, 32'h0000_3010, 4'h0, 0);           // slow rd_rdy
    rd_delay_cfg = -1;

    // randomized traffic over a small tag/set pool
    for (int i = 0; i < 200; i++) begin
      a = {12'h0, 4'($urandom_range(1, 4)), 4'($urandom_range(0, 3)), 4'h0, 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 9) < 3) issue(1, a, 4'($urandom_range(1, 15)), $urandom);
      else                          issue(0, a, 4'h0, 0);
    end

    // reset in the middle of a refill
    manual = 1;
    cpu_req_i = 1; cpu_wr_i = 0; cpu_addr_i = 32'h00F0_0008;
    @(posedge clk); #1;
    cpu_req_i = 0;
    n = 0;
    while (!rd_req_o && n < 20) begin @(posedge clk); #1; n++; end
    check("man_rd_req", rd_req_o, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("man_rd_hold", {rd_req_o, rd_addr_o}, {1'b1, 32'h00F0_0000});
    end
    rd_rdy_i = 1;
    @(posedge clk); #1;
    rd_rdy_i = 0;
    ret_valid_i = 1; ret_data_i = 32'hCAFE_0001;
    @(posedge clk); #1;
    ret_data_i = 32'hCAFE_0002;
    @(posedge clk); #1;
    ret_valid_i = 0;
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("mid_refill_reset");
    @(posedge clk); #1;
    rst_n = 1;
    ref_victim = 0;
    manual = 0;
    @(posedge clk); #1;

    // table contents survive reset, victim restarts at way0
    issue(0, 32'h0000_1234, 4'h0, 0);
    issue(0, 32'h0004_1230, 4'h0, 0);
    issue(0, 32'h0000_1234, 4'h0, 0);
    for (int i = 0; i < 30; i++) begin
      a = {12'h0, 4'($urandom_range(1, 4)), 4'($urandom_range(0, 3)), 4'h0, 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 9) < 3) issue(1, a, 4'($urandom_range(1, 15)), $urandom);
      else                          issue(0, a, 4'h0, 0);
    end

    repeat (4) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("rd_exp_q_empty", rd_exp_q.size(), 0);
    check("wr_exp_q_empty", wr_exp_q.size(), 0);
    check("tw_exp_q_empty", tw_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
